scandoubler_rotate_memif: RTL and testbench

SCANDOUBLER_ROTATE_MEMIF -- requirements
Module: scandoubler_rotate_memif

---
 rtl/scandoubler_rotate_memif.sv | 213 +++++++++++++++++++++
 tb/tb_scandoubler_rotate_memif.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scandoubler_rotate_memif.sv
// scandoubler_rotate_memif
// Frame-buffer memory arbiter for a rotating scandoubler. Incoming video is
// written cornerturned (source column becomes stored row) in 16-word bursts.
// Outgoing rows are fetched in 8-word read bursts. Reads win arbitration by
// default. Defining SCANDOUBLER_ROTATE_MEMIF_WPRIO_EN gives writes priority
// instead.
//
// Ports
//   clk_sys, reset        : clock, synchronous active-high reset
//   vidin_*               : write side: req, frame, row, col, data in; ack out
//   vidout_*              : read side: req, frame, row, col in; data, ack out
//   ram_req/we/addr/wdata : word request to memory
//   ram_ack/rvalid/rdata  : request accepted, in-order read data return
//
// state  | meaning
// IDLE   | arbitrate between read and write requests
// WSETUP | two-cycle wait while the write source catches up after an ack
// WRITE  | write request held until ram_ack
// RISSUE | issuing 8 reads at col_base+0..7
// RDRAIN | all reads issued, waiting for the remaining read data
module scandoubler_rotate_memif #(
    parameter int ADDR_WIDTH = 24,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  vidin_req,
    input  logic                  vidin_frame,
    input  logic [9:0]            vidin_row,
    input  logic [9:0]            vidin_col,
    input  logic [15:0]           vidin_d,
    output logic                  vidin_ack,
    input  logic                  vidout_req,
    input  logic                  vidout_frame,
    input  logic [9:0]            vidout_row,
    input  logic [9:0]            vidout_col,
    output logic [15:0]           vidout_d,
    output logic                  vidout_ack,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_wdata,
    input  logic                  ram_ack,
    input  logic                  ram_rvalid,
    input  logic [15:0]           ram_rdata
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WSETUP = 3'd1;
    localparam logic [2:0] WRITE  = 3'd2;
    localparam logic [2:0] RISSUE = 3'd3;
    localparam logic [2:0] RDRAIN = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  setup_q, setup_d;
    logic [3:0]            wr_cnt_q, wr_cnt_d;
    logic [2:0]            iss_cnt_q, iss_cnt_d;
    logic [3:0]            rv_cnt_q, rv_cnt_d;
    logic [9:0]            col_base_q, col_base_d;
    logic                  rd_frame_q, rd_frame_d;
    logic [9:0]            rd_row_q, rd_row_d;
    logic                  ram_req_q, ram_req_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]           ram_wdata_q, ram_wdata_d;
    logic                  vidin_ack_q, vidin_ack_d;
    logic                  vidout_ack_q, vidout_ack_d;
    logic [15:0]           vidout_d_q, vidout_d_d;
    logic                  rv_hit;
    logic                  go_read, go_write;
    logic [9:0]            next_col;

    function automatic logic [ADDR_WIDTH-1:0] mk_addr(input logic [20:0] idx);
        return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx);
    endfunction

    always_comb begin
        state_d      = state_q;
        setup_d      = setup_q;
        wr_cnt_d     = wr_cnt_q;
        iss_cnt_d    = iss_cnt_q;
        rv_cnt_d     = rv_cnt_q;
        col_base_d   = col_base_q;
        rd_frame_d   = rd_frame_q;
        rd_row_d     = rd_row_q;
        ram_req_d    = ram_req_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        vidin_ack_d  = 1'b0;
        vidout_ack_d = 1'b0;
        vidout_d_d   = vidout_d_q;
        go_read      = 1'b0;
        go_write     = 1'b0;
        next_col     = col_base_q + {7'd0, iss_cnt_q} + 10'd1;

        // Read data is only accepted while a read burst is open and short of 8.
        rv_hit = ram_rvalid && (state_q == RISSUE || state_q == RDRAIN) && (rv_cnt_q != 4'd8);
        if (rv_hit) begin
            vidout_ack_d = 1'b1;
            vidout_d_d   = ram_rdata;
            rv_cnt_d     = rv_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                ram_req_d = 1'b0;
                ram_we_d  = 1'b0;
                rv_cnt_d  = 4'd0;
`ifdef SCANDOUBLER_ROTATE_MEMIF_WPRIO_EN
                go_write = vidin_req;
                go_read  = vidout_req && !vidin_req;
`else
                go_read  = vidout_req;
                go_write = vidin_req && !vidout_req;
`endif
                if (go_read) begin
                    state_d    = RISSUE;
                    col_base_d = vidout_col;
                    rd_frame_d = vidout_frame;
                    rd_row_d   = vidout_row;
                    iss_cnt_d  = 3'd0;
                    ram_req_d  = 1'b1;
                    ram_addr_d = mk_addr({vidout_frame, vidout_row, vidout_col});
                end else if (go_write) begin
                    state_d = WSETUP;
                    setup_d = 1'b0;
                end
            end
            WSETUP: begin
                if (setup_q) begin
                    state_d     = WRITE;
                    setup_d     = 1'b0;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = mk_addr({vidin_frame, vidin_col, vidin_row});
                    ram_wdata_d = vidin_d;
                end else begin
                    setup_d = 1'b1;
                end
            end
            WRITE: begin
                if (ram_ack) begin
                    ram_req_d   = 1'b0;
                    ram_we_d    = 1'b0;
                    vidin_ack_d = 1'b1;
                    wr_cnt_d    = wr_cnt_q + 4'd1;
                    state_d     = (wr_cnt_q == 4'd15) ? IDLE : WSETUP;
                end
            end
            RISSUE: begin
                if (ram_ack) begin
                    iss_cnt_d = iss_cnt_q + 3'd1;
                    if (iss_cnt_q == 3'd7) begin
                        ram_req_d = 1'b0;
                        state_d   = RDRAIN;
                    end else begin
                        ram_addr_d = mk_addr({rd_frame_q, rd_row_q, next_col});
                    end
                end
            end
            RDRAIN: begin
                if (rv_cnt_d == 4'd8) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            setup_q      <= 1'b0;
            wr_cnt_q     <= 4'd0;
            iss_cnt_q    <= 3'd0;
            rv_cnt_q     <= 4'd0;
            col_base_q   <= 10'd0;
            rd_frame_q   <= 1'b0;
            rd_row_q     <= 10'd0;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 16'd0;
            vidin_ack_q  <= 1'b0;
            vidout_ack_q <= 1'b0;
            vidout_d_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            setup_q      <= setup_d;
            wr_cnt_q     <= wr_cnt_d;
            iss_cnt_q    <= iss_cnt_d;
            rv_cnt_q     <= rv_cnt_d;
            col_base_q   <= col_base_d;
            rd_frame_q   <= rd_frame_d;
            rd_row_q     <= rd_row_d;
            ram_req_q    <= ram_req_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            vidin_ack_q  <= vidin_ack_d;
            vidout_ack_q <= vidout_ack_d;
            vidout_d_q   <= vidout_d_d;
        end
    end

    assign ram_req    = ram_req_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign vidin_ack  = vidin_ack_q;
    assign vidout_ack = vidout_ack_q;
    assign vidout_d   = vidout_d_q;

endmodule

// File: tb/tb_scandoubler_rotate_memif.sv
module tb_scandoubler_rotate_memif;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        vidin_req = 1'b0, vidin_frame = 1'b0;
    logic [9:0]  vidin_row = '0, vidin_col = '0;
    logic [15:0] vidin_d = '0;
    logic        vidin_ack;
    logic        vidout_req = 1'b0, vidout_frame = 1'b0;
    logic [9:0]  vidout_row = '0, vidout_col = '0;
    logic [15:0] vidout_d;
    logic        vidout_ack;
    logic        ram_req, ram_we;
    logic [23:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_ack = 1'b0, ram_rvalid = 1'b0;
    logic [15:0] ram_rdata = '0;

    scandoubler_rotate_memif dut (
        .clk_sys(clk_sys), .reset(reset),
        .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
        .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
        .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
        .vidout_col(vidout_col), .vidout_d(vidout_d), .vidout_ack(vidout_ack),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct { logic we; logic [23:0] addr; logic [15:0] data; } req_t;
    typedef struct { int due; logic [15:0] data; } rv_t;

    req_t        exp_req[$];
    logic [15:0] exp_rd[$];
    rv_t         rv_q[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int acc_cnt = 0, ack_limit = 1000000;
    int vo_ack_cnt = 0, last_vi = -100;
    bit stray = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Memory model: acknowledges requests, checks them against the expected
    // request queue, returns read data (addr low 16 bits) 4 cycles later.
    always @(negedge clk_sys) begin
        req_t e;
        ram_rvalid = 1'b0;
        ram_rdata  = 16'h0000;
        if (stray) begin
            ram_rvalid = 1'b1;
            ram_rdata  = 16'hBEEF;
        end else if (rv_q.size() > 0 && rv_q[0].due <= cyc) begin
            ram_rvalid = 1'b1;
            ram_rdata  = rv_q[0].data;
            void'(rv_q.pop_front());
        end
        ram_ack = 1'b0;
        if (ram_req === 1'b1 && acc_cnt < ack_limit) begin
            ram_ack = 1'b1;
            acc_cnt++;
            if (exp_req.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL ram_req_unexpected: got we=%b addr=%h, required no request", ram_we, ram_addr);
            end else begin
                e = exp_req.pop_front();
                chk("ram_we", {31'd0, ram_we}, {31'd0, e.we});
                chk("ram_addr", {8'd0, ram_addr}, {8'd0, e.addr});
                if (e.we) chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, e.data});
            end
            if (!ram_we) rv_q.push_back('{cyc + 4, ram_addr[15:0]});
        end
    end

    // Output monitor: pops expected read data on every vidout_ack.
    always @(negedge clk_sys) begin
        if (vidout_ack === 1'b1) begin
            vo_ack_cnt++;
            if (exp_rd.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL vidout_ack_unexpected: got ack with vidout_d=%h, required no ack", vidout_d);
            end else begin
                chk("vidout_d", {16'd0, vidout_d}, {16'd0, exp_rd.pop_front()});
            end
        end
        if (vidin_ack === 1'b1) begin
            chk("vidin_ack_gap_ge3", {31'd0, (cyc - last_vi) >= 3}, 32'd1);
            last_vi = cyc;
        end
    end

    function automatic void push_writes(input logic fr, input logic [9:0] row,
                                        input logic [9:0] col0, input logic [15:0] d0);
        for (int i = 0; i < 16; i++) begin
            logic [9:0] c;
            c = col0 + 10'(i);
            exp_req.push_back('{1'b1, 24'({fr, c, row}), d0 + 16'(i)});
        end
    endfunction

    function automatic void push_reads(input logic fr, input logic [9:0] row,
                                       input logic [9:0] col0, input int n, input bit with_data);
        for (int i = 0; i < n; i++) begin
            logic [9:0]  c;
            logic [23:0] a;
            c = col0 + 10'(i);
            a = 24'({fr, row, c});
            exp_req.push_back('{1'b0, a, 16'h0000});
            if (with_data) exp_rd.push_back(a[15:0]);
        end
    endfunction

    task automatic run_write(input logic fr, input logic [9:0] row,
                             input logic [9:0] col0, input logic [15:0] d0);
        int n = 0;
        vidin_frame = fr; vidin_row = row; vidin_col = col0; vidin_d = d0;
        vidin_req = 1'b1;
        for (int t = 0; t < 2000 && n < 16; t++) begin
            @(negedge clk_sys);
            if (vidin_ack) begin
                n++;
                vidin_col = vidin_col + 10'd1;
                vidin_d   = vidin_d + 16'd1;
            end
        end
        vidin_req = 1'b0;
        chk("write_ack_count", n, 16);
    endtask

    task automatic run_read(input logic fr, input logic [9:0] row,
                            input logic [9:0] col0, input int nwords);
        int n = 0;
        vidout_frame = fr; vidout_row = row; vidout_col = col0;
        vidout_req = 1'b1;
        for (int t = 0; t < 2000 && n < nwords; t++) begin
            @(negedge clk_sys);
            if (vidout_ack) begin
                n++;
                vidout_col = vidout_col + 10'd1;
            end
        end
        vidout_req = 1'b0;
        chk("read_ack_count", n, nwords);
    endtask

    task automatic wait_vidin_acks(input int target);
        int n = 0;
        for (int t = 0; t < 1000 && n < target; t++) begin
            @(negedge clk_sys);
            if (vidin_ack) n++;
        end
        chk("wait_vidin_acks", n, target);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim, vo0;

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", {8'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        chk("rst_vidin_ack", {31'd0, vidin_ack}, 32'd0);
        chk("rst_vidout_ack", {31'd0, vidout_ack}, 32'd0);
        chk("rst_vidout_d", {16'd0, vidout_d}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // 16-word cornerturned write burst: frame 1, row 5, cols 0x120..0x12F.
        push_writes(1'b1, 10'd5, 10'h120, 16'hA000);
        run_write(1'b1, 10'd5, 10'h120, 16'hA000);
        repeat (4) @(negedge clk_sys);

        // Two read bursts: frame 0, row 3, cols 0..15 -> data 0x0C00..0x0C0F.
        push_reads(1'b0, 10'd3, 10'd0, 16, 1'b1);
        run_read(1'b0, 10'd3, 10'd0, 16);
        repeat (8) @(negedge clk_sys);

        // Simultaneous requests: arbitration order depends on write priority.
`ifdef SCANDOUBLER_ROTATE_MEMIF_WPRIO_EN
        push_writes(1'b0, 10'd9, 10'h010, 16'h5500);
        push_reads(1'b1, 10'd7, 10'h040, 8, 1'b1);
`else
        push_reads(1'b1, 10'd7, 10'h040, 8, 1'b1);
        push_writes(1'b0, 10'd9, 10'h010, 16'h5500);
`endif
        fork
            run_write(1'b0, 10'd9, 10'h010, 16'h5500);
            run_read(1'b1, 10'd7, 10'h040, 8);
        join
        repeat (8) @(negedge clk_sys);

        // Read request arriving during write word 7 waits for the full burst.
        push_writes(1'b1, 10'h200, 10'h300, 16'h1234);
        push_reads(1'b0, 10'd1, 10'h080, 8, 1'b1);
        fork
            run_write(1'b1, 10'h200, 10'h300, 16'h1234);
            begin
                wait_vidin_acks(6);
                run_read(1'b0, 10'd1, 10'h080, 8);
            end
        join
        repeat (8) @(negedge clk_sys);

        // Column wrap: 0x3FC..0x3FF, 0x000..0x003 on row 0x2AA frame 1.
        push_reads(1'b1, 10'h2AA, 10'h3FC, 8, 1'b1);
        run_read(1'b1, 10'h2AA, 10'h3FC, 8);
        repeat (8) @(negedge clk_sys);

        // Reset after 3 of 8 reads issued, then stray rvalids.
        push_reads(1'b0, 10'd3, 10'h040, 3, 1'b0);
        lim = acc_cnt + 3;
        ack_limit = lim;
        vo0 = vo_ack_cnt;
        vidout_frame = 1'b0; vidout_row = 10'd3; vidout_col = 10'h040;
        vidout_req = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk_sys);
            if (acc_cnt >= lim) break;
        end
        chk("reads_issued_before_reset", acc_cnt, lim);
        reset = 1'b1;
        vidout_req = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        stray = 1'b1;
        repeat (2) @(negedge clk_sys);
        stray = 1'b0;
        repeat (8) @(negedge clk_sys);
        chk("reset_vidout_ack_count", vo_ack_cnt - vo0, 0);
        chk("reset_ram_req", {31'd0, ram_req}, 32'd0);
        chk("reset_state_idle", {29'd0, dut.state_q}, 32'd0);
        rv_q.delete();
        ack_limit = 1000000;

        chk("exp_req_drained", exp_req.size(), 0);
        chk("exp_rd_drained", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
